run_detector_seq: RTL and testbench
===================================

RUN_DETECTOR_SEQ -- requirements
Module: run_detector_seq

Interface
REQ-001 Parameter: WIDTH, 8, bit width of the input word; legal range 2..32.
REQ-002 Parameter: MIN_LEN, 1, minimum run length counted; legal range 1..WIDTH.
REQ-003 Derived constant: CW = $clog2(WIDTH+1), width of the count outputs.
REQ-004 Port: clk  input  1  single clock, rising-edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: start  input  1  request to capture din and scan it.
REQ-007 Port: din  input  WIDTH  word to analyse.
REQ-008 Port: busy  output  1  high while scanning.
REQ-009 Port: done  output  1  one-cycle pulse when results update.
REQ-010 Port: run_cnt  output  CW  number of runs of 1s with length >= MIN_LEN.
REQ-011 Port: max_run  output  CW  length of the longest run of 1s.
REQ-012 Port: led  output  WIDTH  copy of the last captured word.
REQ-013 Port: seg  output  8  active-low 7-segment code {dp,g,f,e,d,c,b,a} for max_run[3:0].

Function
REQ-014 FSM states: IDLE, SCAN, DONE.
REQ-015 Transitions: IDLE->SCAN on start; SCAN->DONE after WIDTH bit cycles; DONE->SCAN on start, otherwise DONE->IDLE.
REQ-016 On acceptance (start=1 in IDLE or DONE), the block shall capture din into a shift register and into led, and shall clear the internal accumulators.
REQ-017 SCAN shall examine one bit per cycle, MSB first, and shall spend exactly WIDTH cycles in SCAN.
REQ-018 The current-run counter increments on a 1. On a 0, a nonzero run closes: if its length >= MIN_LEN, the run count increments, and max is updated if the run length exceeds it.
REQ-019 A run still open after the LSB shall be closed by the same rule on the SCAN->DONE edge.
REQ-020 max_run shall track all runs, including those shorter than MIN_LEN.
REQ-021 run_cnt and max_run shall update only on the SCAN->DONE edge and shall hold until the next DONE.
REQ-022 done shall be 1 only in DONE. Latency: if start is accepted at edge k, done is high in the cycle after edge k+WIDTH.
REQ-023 busy shall be 1 only in SCAN. start shall be ignored while busy.
REQ-024 The hex decoder shall produce: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E. dp is always off.
REQ-025 Counters shall be sized so that they cannot overflow for any WIDTH; no saturation logic is required.

Reset
REQ-026 When rst_n=0, all state shall clear asynchronously: state=IDLE; busy=0, done=0, run_cnt=0, max_run=0, led=0; seg shall show the code for 0 (C0).
REQ-027 Reset asserted mid-SCAN shall abort the scan with no done pulse. Operation resumes on the first start after rst_n deasserts.

Configuration
REQ-028 Macro RUN_DET_SEG_EN: when defined, seg is driven by the REQ-024 decoder.
REQ-029 When RUN_DET_SEG_EN is undefined, no decoder logic is built and seg shall be constant 8'hFF (blank).

Verification (WIDTH=8, MIN_LEN=1, RUN_DET_SEG_EN defined unless noted)
REQ-030 din=8'b11001110, start pulse -> done 8 cycles after acceptance; run_cnt=2, max_run=3, seg=8'hB0, led=8'hCE.
REQ-031 din=8'hFF -> run_cnt=1, max_run=8, seg=8'h80. Then din=8'h00 -> run_cnt=0, max_run=0, seg=8'hC0.
REQ-032 din=8'b10101011 -> run_cnt=4, max_run=2. Same stimulus with MIN_LEN=2 -> run_cnt=1, max_run=2.
REQ-033 start re-pulsed during SCAN with a different din -> ignored; led and results reflect the first word. start held high in DONE -> back-to-back scan, done pulses 9 cycles apart.
REQ-034 rst_n low at the 4th SCAN cycle -> all outputs 0, seg=8'hC0, no done pulse. A build without RUN_DET_SEG_EN -> seg=8'hFF for all of REQ-030..REQ-032.

Source files
------------

// File: rtl/run_detector_seq.sv
// run_detector_seq
//   Captures a word on start, scans it one bit per cycle (MSB first) and
//   reports the number of runs of 1s at least MIN_LEN long and the length of
//   the longest run of 1s. Results are published on the SCAN->DONE edge and
//   hold until the next scan completes.
//
//   state | meaning
//   IDLE  | waiting for start
//   SCAN  | examining one bit per cycle, WIDTH cycles total
//   DONE  | results just published; start here begins a back-to-back scan
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request to capture din (ignored while busy)
//   din      word to analyse
//   busy     high while in SCAN
//   done     one-cycle pulse in DONE
//   run_cnt  runs of 1s with length >= MIN_LEN
//   max_run  longest run of 1s (all runs count)
//   led      last captured word
//   seg      active-low 7-segment {dp,g,f,e,d,c,b,a} of max_run[3:0]
//
// Build option
//   RUN_DET_SEG_EN  defined: seg driven by the hex decoder
//                   undefined: no decoder, seg is constant 8'hFF (blank)

module run_detector_seq #(
  parameter  int WIDTH   = 8,
  parameter  int MIN_LEN = 1,
  localparam int CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    run_cnt,
  output logic [CW-1:0]    max_run,
  output logic [WIDTH-1:0] led,
  output logic [7:0]       seg
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [CW-1:0] MIN_LEN_C = CW'(MIN_LEN);
  localparam logic [CW-1:0] WIDTH_C   = CW'(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] led_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [CW-1:0]    cur_q, cur_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    max_q, max_d;
  logic [CW-1:0]    cnt_fin, max_fin;
  logic [CW-1:0]    run_cnt_q, max_run_q;
  logic             busy_q, done_q;
  logic             bit_w;

  // Accumulator update for the bit under examination. cnt_fin/max_fin also
  // close a run that is still open when the LSB is a 1.
  always_comb begin
    bit_w = shift_q[WIDTH-1];
    cur_d = cur_q;
    cnt_d = cnt_q;
    max_d = max_q;
    if (bit_w) begin
      cur_d = cur_q + 1'b1;
    end else begin
      cur_d = '0;
      if (cur_q != '0) begin
        if (cur_q >= MIN_LEN_C) cnt_d = cnt_q + 1'b1;
        if (cur_q > max_q)      max_d = cur_q;
      end
    end
    cnt_fin = cnt_d;
    max_fin = max_d;
    if (bit_w) begin
      if (cur_d >= MIN_LEN_C) cnt_fin = cnt_d + 1'b1;
      if (cur_d > max_d)      max_fin = cur_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      led_q     <= '0;
      bit_cnt_q <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      max_q     <= '0;
      run_cnt_q <= '0;
      max_run_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= SCAN;
            busy_q    <= 1'b1;
            shift_q   <= din;
            led_q     <= din;
            bit_cnt_q <= WIDTH_C;
            cur_q     <= '0;
            cnt_q     <= '0;
            max_q     <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        SCAN: begin
          shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
          cur_q     <= cur_d;
          cnt_q     <= cnt_d;
          max_q     <= max_d;
          bit_cnt_q <= bit_cnt_q - 1'b1;
          if (bit_cnt_q == CW'(1)) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            run_cnt_q <= cnt_fin;
            max_run_q <= max_fin;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign run_cnt = run_cnt_q;
  assign max_run = max_run_q;
  assign led     = led_q;

`ifdef RUN_DET_SEG_EN
  logic [3:0] nib;
  assign nib = 4'(max_run_q);

  always_comb begin
    seg = 8'hFF;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end
`else
  assign seg = 8'hFF;
`endif

endmodule

// File: tb/tb_run_detector_seq.sv
module tb_run_detector_seq;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

`ifdef RUN_DET_SEG_EN
  localparam bit SEG_EN = 1'b1;
`else
  localparam bit SEG_EN = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  din   = '0;

  logic          busy, done, busy2, done2;
  logic [CW-1:0] run_cnt, max_run, run_cnt2, max_run2;
  logic [W-1:0]  led, led2;
  logic [7:0]    seg, seg2;

  run_detector_seq #(.WIDTH(W), .MIN_LEN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din),
    .busy(busy), .done(done), .run_cnt(run_cnt), .max_run(max_run),
    .led(led), .seg(seg)
  );

  run_detector_seq #(.WIDTH(W), .MIN_LEN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din),
    .busy(busy2), .done(done2), .run_cnt(run_cnt2), .max_run(max_run2),
    .led(led2), .seg(seg2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic int seg_of(input int v);
    logic [7:0] tbl [16];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    if (!SEG_EN) return 8'hFF;
    return int'(tbl[v % 16]);
  endfunction

  // Reference: split the word into runs of 1s and tally them.
  task automatic ref_scan(input logic [W-1:0] w, input int minlen,
                          output int cnt, output int mx);
    int run;
    run = 0; cnt = 0; mx = 0;
    for (int i = W - 1; i >= -1; i--) begin
      if (i >= 0 && w[i]) run++;
      else begin
        if (run >= minlen && run > 0) cnt++;
        if (run > mx) mx = run;
        run = 0;
      end
    end
  endtask

  // Timing model: accepted word keeps the block busy for W cycles, then a
  // single done cycle publishes the tallies.
  int           m_left, m_cnt1, m_max, m_cnt2, m_junk;
  bit           m_done;
  logic [W-1:0] m_word, m_led;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_word = '0; m_led = '0;
      m_cnt1 = 0; m_max = 0; m_cnt2 = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_done = 0;
      if (m_left == 0) begin
        ref_scan(m_word, 1, m_cnt1, m_max);
        ref_scan(m_word, 2, m_cnt2, m_junk);
        m_done = 1;
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_word = din;
        m_led  = din;
        m_left = W;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",     int'(busy),     int'(m_left > 0));
      chk("done",     int'(done),     int'(m_done));
      chk("run_cnt",  int'(run_cnt),  m_cnt1);
      chk("max_run",  int'(max_run),  m_max);
      chk("led",      int'(led),      int'(m_led));
      chk("seg",      int'(seg),      seg_of(m_max));
      chk("run_cnt2", int'(run_cnt2), m_cnt2);
      chk("max_run2", int'(max_run2), m_max);
      chk("done2",    int'(done2),    int'(m_done));
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_word(input logic [W-1:0] w, output int lat);
    @(negedge clk);
    start = 1'b1; din = w;
    @(posedge clk); #1;
    start = 1'b0; din = W'($urandom);
    wait_done(lat);
  endtask

  int lat, t1, t2, dcount;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    int'(busy),    0);
    chk("rst_done",    int'(done),    0);
    chk("rst_run_cnt", int'(run_cnt), 0);
    chk("rst_max_run", int'(max_run), 0);
    chk("rst_led",     int'(led),     0);
    chk("rst_seg",     int'(seg),     SEG_EN ? 8'hC0 : 8'hFF);
    chk_en = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_word(8'b11001110, lat);
    chk("ce_latency", lat, 8);
    chk("ce_run_cnt", int'(run_cnt), 2);
    chk("ce_max_run", int'(max_run), 3);
    chk("ce_seg",     int'(seg),     SEG_EN ? 8'hB0 : 8'hFF);
    chk("ce_led",     int'(led),     8'hCE);

    run_word(8'hFF, lat);
    chk("ff_run_cnt", int'(run_cnt), 1);
    chk("ff_max_run", int'(max_run), 8);
    chk("ff_seg",     int'(seg),     SEG_EN ? 8'h80 : 8'hFF);
    run_word(8'h00, lat);
    chk("00_run_cnt", int'(run_cnt), 0);
    chk("00_max_run", int'(max_run), 0);
    chk("00_seg",     int'(seg),     SEG_EN ? 8'hC0 : 8'hFF);

    run_word(8'b10101011, lat);
    chk("ab_run_cnt",      int'(run_cnt),  4);
    chk("ab_max_run",      int'(max_run),  2);
    chk("ab_run_cnt_min2", int'(run_cnt2), 1);
    chk("ab_max_run_min2", int'(max_run2), 2);

    // start during SCAN must be ignored
    @(negedge clk);
    start = 1'b1; din = 8'hCE;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1; start = 1'b1; din = 8'h0F;
    @(posedge clk); #1; start = 1'b0;
    wait_done(lat);
    chk("ign_led",     int'(led),     8'hCE);
    chk("ign_run_cnt", int'(run_cnt), 2);
    chk("ign_max_run", int'(max_run), 3);

    // start held high through DONE: back-to-back scans
    repeat (2) @(negedge clk);
    start = 1'b1; din = 8'h5A;
    t1 = -1; t2 = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        if (t1 < 0) t1 = cyc;
        else begin
          t2 = cyc;
          break;
        end
      end
    end
    @(negedge clk); start = 1'b0;
    chk("b2b_spacing", t2 - t1, 9);
    chk("b2b_run_cnt", int'(run_cnt), 3);
    chk("b2b_max_run", int'(max_run), 2);
    repeat (12) @(negedge clk);

    // reset during the 4th SCAN cycle
    @(negedge clk);
    start = 1'b1; din = 8'hFF;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",    int'(busy),    0);
    chk("mid_rst_done",    int'(done),    0);
    chk("mid_rst_run_cnt", int'(run_cnt), 0);
    chk("mid_rst_max_run", int'(max_run), 0);
    chk("mid_rst_led",     int'(led),     0);
    chk("mid_rst_seg",     int'(seg),     SEG_EN ? 8'hC0 : 8'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("mid_rst_no_done", dcount, 0);
    run_word(8'b11001110, lat);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_run_cnt", int'(run_cnt), 2);

    // randomized traffic, including starts while busy
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      din   = W'($urandom);
    end
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
